// File: rtl/sha256_pkg.sv
// ============================================================================
//  Module  : sha256_pkg
//  Brief   : Shared constants and FSM encoding for the SHA-256 schedule control
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

    localparam int SHA256_ROUNDS    = 64;
    localparam int SHA256_BLK_WORDS = 16;
    localparam int SHA256_DW        = 32;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/sha256_blk_buf.sv
// ============================================================================
//  Module  : sha256_blk_buf
//  Brief   : 16-entry message-word buffer, one sync write, one async read port
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_blk_buf
    import sha256_pkg::*;
#(
    parameter int DW = SHA256_DW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [3:0]    raddr_i,
    output logic [DW-1:0] rdata_o
);

    // Contents need no reset: reads are only consumed after a full block load.
    logic [DW-1:0] mem_q [SHA256_BLK_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/sha256_sched_ctrl.sv
// ============================================================================
//  Module  : sha256_sched_ctrl
//  Brief   : Loads 16-word blocks and sequences 64 uninterrupted SHA-256 rounds
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_sched_ctrl
    import sha256_pkg::*;
#(
    parameter int DW        = SHA256_DW,
    parameter int BLK_WORDS = SHA256_BLK_WORDS,
    parameter int ROUNDS    = SHA256_ROUNDS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          sched_en,
    output logic [5:0]    round_idx,
    output logic [DW-1:0] m_word,
    output logic          round_valid,
    output logic          block_first,
    output logic          block_done,
    output logic          block_last,
    output logic          busy
);

    localparam logic [4:0] c_full_cnt   = 5'(BLK_WORDS);
    localparam logic [4:0] c_last_wr    = 5'(BLK_WORDS - 1);
    localparam logic [5:0] c_last_round = 6'(ROUNDS - 1);
    localparam logic [5:0] c_sched_rnd  = 6'(BLK_WORDS);
    localparam logic [5:0] c_last_read  = 6'(BLK_WORDS - 1);

    sched_state_e state_q, state_d;
    logic [5:0]   round_q, round_d;
    logic [4:0]   wr_cnt_q, wr_cnt_d;
    logic         load_last_q, load_last_d;
    logic         run_last_q, run_last_d;
    logic         first_pend_q, first_pend_d;
    logic         block_first_q, block_first_d;

    logic          w_run;
    logic          w_last_rnd;
    logic          w_ready;
    logic          w_acc;
    logic [4:0]    w_cnt_acc;
    logic          w_first_src;
    logic [DW-1:0] w_rdata;

    assign w_run       = (state_q == RUN);
    assign w_last_rnd  = w_run && (round_q == c_last_round);
    // Rounds 0..15 still read the buffer, so loading waits for round 16.
    assign w_ready     = !reset && (wr_cnt_q < c_full_cnt)
                         && (!w_run || (round_q >= c_sched_rnd));
    assign w_acc       = in_valid && w_ready;
    assign w_cnt_acc   = wr_cnt_q + 5'(w_acc);
    assign w_first_src = first_pend_q || (w_last_rnd && run_last_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= LOAD;
            round_q       <= '0;
            wr_cnt_q      <= '0;
            load_last_q   <= 1'b0;
            run_last_q    <= 1'b0;
            first_pend_q  <= 1'b1;
            block_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            wr_cnt_q      <= wr_cnt_d;
            load_last_q   <= load_last_d;
            run_last_q    <= run_last_d;
            first_pend_q  <= first_pend_d;
            block_first_q <= block_first_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        wr_cnt_d      = w_cnt_acc;
        load_last_d   = load_last_q;
        run_last_d    = run_last_q;
        first_pend_d  = w_first_src;
        block_first_d = block_first_q;

        if (w_acc && (wr_cnt_q == c_last_wr)) begin
            load_last_d = in_last;
        end

        if (w_run && !w_last_rnd) begin
            round_d = round_q + 6'd1;
            if (round_q == c_last_read) begin
                wr_cnt_d = '0;
            end
        end else if (w_cnt_acc == c_full_cnt) begin
            // Covers both LOAD->RUN and the bubble-free round 63 -> round 0 wrap.
            state_d       = RUN;
            round_d       = '0;
            run_last_d    = load_last_d;
            block_first_d = w_first_src;
            first_pend_d  = 1'b0;
        end else begin
            state_d = LOAD;
            round_d = '0;
        end
    end

    sha256_blk_buf #(
        .DW (DW)
    ) u_buf (
        .clk     (clk),
        .we_i    (w_acc),
        .waddr_i (wr_cnt_q[3:0]),
        .wdata_i (in_data),
        .raddr_i (round_q[3:0]),
        .rdata_o (w_rdata)
    );

    assign in_ready    = w_ready;
    assign sched_en    = w_run;
    assign round_valid = w_run;
    assign round_idx   = round_q;
    assign m_word      = (w_run && (round_q < c_sched_rnd)) ? w_rdata : '0;
    assign block_done  = w_last_rnd;
    assign block_last  = w_last_rnd && run_last_q;
    assign block_first = w_run && block_first_q;
    assign busy        = w_run || (wr_cnt_q != 5'd0);

endmodule

`default_nettype wire

// File: tb/tb_sha256_sched_ctrl.sv
// ============================================================================
//  Module  : tb_sha256_sched_ctrl
//  Brief   : Randomised scenario bench for sha256_sched_ctrl with a queue model
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_sched_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_ready, sched_en, round_valid, block_first, block_done, block_last, busy;
    logic [5:0]  round_idx;
    logic [31:0] m_word;

    sha256_sched_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .sched_en    (sched_en),
        .round_idx   (round_idx),
        .m_word      (m_word),
        .round_valid (round_valid),
        .block_first (block_first),
        .block_done  (block_done),
        .block_last  (block_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } word_t;

    // Sender queue plus block-level model: pending words, the running block, round number.
    word_t       tx[$];
    logic [31:0] pend[$];
    logic [31:0] cur[16];
    int          mr;
    bit          pend_last, cur_last, cur_first, new_msg, drv_rst;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic void model_reset();
        mr = -1; pend.delete(); pend_last = 0; cur_last = 0; cur_first = 0; new_msg = 1;
    endfunction

    function automatic bit m_ready();
        return !drv_rst && (mr < 0 || mr >= 16) && (pend.size() < 16);
    endfunction

    function automatic bit idle();
        return (mr < 0) && (tx.size() == 0) && (pend.size() == 0);
    endfunction

    function automatic logic [44:0] exp_vec();
        bit          run;
        logic [31:0] mw;
        logic [5:0]  idx;
        run = (mr >= 0);
        mw  = (run && mr < 16) ? cur[mr] : 32'h0;
        idx = run ? 6'(mr) : 6'd0;
        return {m_ready(), run, run, idx, mw, (mr == 63), (mr == 63) && cur_last,
                run && cur_first, run || (pend.size() > 0)};
    endfunction

    function automatic logic [44:0] dut_vec();
        return {in_ready, sched_en, round_valid, round_idx, m_word,
                block_done, block_last, block_first, busy};
    endfunction

    task automatic present(input bit want, input bit rst);
        @(negedge clk);
        drv_rst = rst;
        reset   = rst;
        if (want && tx.size() > 0) begin
            in_valid = 1'b1; in_data = tx[0].d; in_last = tx[0].l;
        end else begin
            in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom);
        end
        #1;
    endtask

    task automatic commit();
        bit acc;
        acc = in_valid && m_ready();
        if (drv_rst) begin
            model_reset();
            return;
        end
        if (acc) begin
            pend.push_back(in_data);
            if (pend.size() == 16) pend_last = in_last;
            void'(tx.pop_front());
        end
        if (mr == 63 && cur_last) new_msg = 1;
        if (mr < 0 || mr == 63) begin
            if (pend.size() == 16) begin
                for (int i = 0; i < 16; i++) cur[i] = pend[i];
                cur_last = pend_last; cur_first = new_msg; new_msg = 0;
                pend.delete(); mr = 0;
            end else begin
                mr = -1;
            end
        end else begin
            mr++;
        end
    endtask

    task automatic queue_block(input bit last, input bit abc);
        word_t w;
        for (int i = 0; i < 16; i++) begin
            w.d = abc ? ((i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0) : $urandom;
            w.l = (i == 15) ? last : 1'($urandom);
            tx.push_back(w);
        end
    endtask

    task automatic test_reset();
        model_reset();
        for (int c = 0; c < 2; c++) begin
            present(1'b0, 1'b1);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_hold c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            commit();
        end
        present(1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== {1'b1, 44'h0}) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), {1'b1, 44'h0});
        end
        commit();
    endtask

    task automatic test_abc();
        int          last_acc = -1, run_start = -1, dones = 0;
        bit          done_ok = 0;
        logic [31:0] m0 = 32'h0;
        queue_block(1'b1, 1'b1);
        for (int c = 0; c < 200; c++) begin
            present(1'b1, 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL abc_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (sched_en && round_idx == 6'd0 && run_start < 0) begin run_start = c; m0 = m_word; end
            if (block_done) begin dones++; done_ok = block_last && block_first; end
            if (in_valid && in_ready && tx.size() == 1) last_acc = c;
            commit();
            if (idle()) break;
        end
        n_checks++;
        if (run_start != last_acc + 1) begin
            n_fail++; $display("FAIL abc_start_latency got=%0d exp=%0d", run_start, last_acc + 1);
        end
        n_checks++;
        if (m0 !== 32'h61626380) begin
            n_fail++; $display("FAIL abc_word0 got=%h exp=61626380", m0);
        end
        n_checks++;
        if (dones != 1 || !done_ok) begin
            n_fail++; $display("FAIL abc_done got=%0d/%0d exp=1/1", dones, done_ok);
        end
        n_checks++;
        if (!idle()) begin n_fail++; $display("FAIL abc_timeout got=busy exp=idle"); end
    endtask

    task automatic test_back_to_back();
        int       gaps = 0, early = 0, first_acc_r = -1, dones = 0;
        bit       started = 0, wrapped = 0;
        logic [5:0] prev_r = 6'd0;
        logic [1:0] flags[2];
        flags[0] = 2'b11; flags[1] = 2'b11;
        queue_block(1'b0, 1'b0);
        queue_block(1'b1, 1'b0);
        for (int c = 0; c < 400; c++) begin
            present(1'b1, 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL b2b_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (started && dones < 2 && !sched_en) gaps++;
            if (sched_en) started = 1;
            if (sched_en && round_idx < 6'd16 && in_ready) early++;
            if (sched_en && in_valid && in_ready && first_acc_r < 0) first_acc_r = int'(round_idx);
            if (sched_en && round_idx == 6'd0 && prev_r == 6'd63) wrapped = 1;
            prev_r = sched_en ? round_idx : 6'd0;
            if (block_done && dones < 2) begin flags[dones] = {block_first, block_last}; dones++; end
            commit();
            if (idle()) break;
        end
        n_checks++;
        if (gaps != 0 || !wrapped) begin
            n_fail++; $display("FAIL b2b_continuous got=gaps%0d/wrap%0d exp=gaps0/wrap1", gaps, wrapped);
        end
        n_checks++;
        if (early != 0 || first_acc_r != 16) begin
            n_fail++; $display("FAIL b2b_ready_hold got=%0d/%0d exp=0/16", early, first_acc_r);
        end
        n_checks++;
        if (dones != 2 || flags[0] !== 2'b10 || flags[1] !== 2'b01) begin
            n_fail++; $display("FAIL b2b_flags got=%0d/%b/%b exp=2/10/01", dones, flags[0], flags[1]);
        end
        n_checks++;
        if (!idle()) begin n_fail++; $display("FAIL b2b_timeout got=busy exp=idle"); end
    endtask

    task automatic test_partial();
        int  dones = 0, last_acc = -1, restart = -1;
        bit  after_ok = 0, chk_next = 0;
        queue_block(1'b0, 1'b0);
        queue_block(1'b1, 1'b0);
        for (int c = 0; c < 400; c++) begin
            present((mr < 0) || (pend.size() < 10), 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL partial_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (chk_next) begin after_ok = !sched_en && in_ready && round_idx == 6'd0; chk_next = 0; end
            if (dones == 1 && !sched_en) restart = -1;
            if (dones == 1 && sched_en && restart < 0) restart = c;
            if (block_done) begin dones++; if (dones == 1) chk_next = 1; end
            if (in_valid && in_ready && tx.size() == 1) last_acc = c;
            commit();
            if (idle()) break;
        end
        n_checks++;
        if (!after_ok) begin n_fail++; $display("FAIL partial_load got=0 exp=1"); end
        n_checks++;
        if (restart != last_acc + 1) begin
            n_fail++; $display("FAIL partial_restart got=%0d exp=%0d", restart, last_acc + 1);
        end
        n_checks++;
        if (dones != 2 || !idle()) begin n_fail++; $display("FAIL partial_done got=%0d exp=2", dones); end
    endtask

    task automatic test_reset_mid();
        int dones = 0, post_dones = 0;
        bit hit = 0, first_ok = 0;
        queue_block(1'b0, 1'b0);
        queue_block(1'b0, 1'b0);
        for (int c = 0; c < 300 && !hit; c++) begin
            present(1'b1, 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rstmid_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (block_done) dones++;
            if (dones == 1 && sched_en && round_idx == 6'd30) hit = 1;
            else commit();
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL rstmid_reach got=0 exp=1"); end
        present(1'b0, 1'b1);
        tx.delete();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=0", in_ready); end
        commit();
        present(1'b0, 1'b0);
        n_checks++;
        if ({sched_en, round_idx, busy, block_done} !== 9'h0) begin
            n_fail++; $display("FAIL rstmid_after got=%h exp=0", {sched_en, round_idx, busy, block_done});
        end
        commit();
        queue_block(1'b1, 1'b0);
        for (int c = 0; c < 200; c++) begin
            present(1'b1, 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rstmid_fresh c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (block_done) begin post_dones++; first_ok = block_first && block_last; end
            commit();
            if (idle()) break;
        end
        n_checks++;
        if (post_dones != 1 || !first_ok) begin
            n_fail++; $display("FAIL rstmid_fresh_done got=%0d/%0d exp=1/1", post_dones, first_ok);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 5; b++) queue_block(1'($urandom), 1'b0);
        for (int c = 0; c < 3000; c++) begin
            present($urandom_range(0, 3) != 0, 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            commit();
            if (idle()) break;
        end
        n_checks++;
        if (!idle()) begin n_fail++; $display("FAIL random_timeout got=busy exp=idle"); end
    endtask

    initial begin
        drv_rst = 1;
        test_reset();
        test_abc();
        test_back_to_back();
        test_partial();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
